// File: rtl/game_round_ctrl.sv
// Round controller for the duck-shooting game.
// It tracks the score, the remaining ducks, the ammo for the current duck and the
// round timer. It asks for a new duck after each one is resolved, and flags the end
// of the round to the game-control FSM.
module game_round_ctrl #(
    parameter int CLK_FREQ_HZ    = 65_000_000,
    parameter int GAME_TIME_S    = 60,
    parameter int DUCKS_PER_GAME = 10,
    parameter int AMMO_PER_DUCK  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_enable,
    input  logic       game_enable_posedge,
    input  logic       left_mouse,
    input  logic       duck_hit,
    input  logic       duck_escaped,
    output logic       game_finished,
    output logic       duck_respawn,
    output logic [7:0] score,
    output logic [7:0] ducks_left,
    output logic [3:0] ammo,
    output logic [7:0] time_left
);

    // The prescaler must be at least one bit wide, even when one clock equals one second.
    localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_FREQ_HZ - 1);
    localparam logic [7:0]    GAME_TIME  = 8'(GAME_TIME_S);
    localparam logic [7:0]    DUCKS_INIT = 8'(DUCKS_PER_GAME);
    localparam logic [3:0]    AMMO_INIT  = 4'(AMMO_PER_DUCK);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESPAWN  = 2'd1,
        ARMED    = 2'd2,
        FINISHED = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic          mouse_prev;

    logic shot;
    logic tick;
    logic timeout;
    logic resolve;
    logic last_duck;

    // Decode of the per-cycle events that the state register reacts to.
    always_comb begin
        shot      = left_mouse & ~mouse_prev;
        tick      = (prescaler == PRESC_MAX);
        timeout   = tick && (time_left <= 8'd1);
        resolve   = duck_hit | duck_escaped;
        last_duck = (ducks_left <= 8'd1);
    end

    // Round FSM. It also owns the counters and all of the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            prescaler     <= '0;
            mouse_prev    <= 1'b0;
            game_finished <= 1'b0;
            duck_respawn  <= 1'b0;
            score         <= 8'd0;
            ducks_left    <= 8'd0;
            ammo          <= 4'd0;
            time_left     <= 8'd0;
        end else begin
            mouse_prev   <= left_mouse;
            duck_respawn <= 1'b0;

            if (game_enable_posedge) begin
                // A new game can be started from any state.
                state         <= RESPAWN;
                duck_respawn  <= 1'b1;
                game_finished <= 1'b0;
                score         <= 8'd0;
                ducks_left    <= DUCKS_INIT;
                ammo          <= AMMO_INIT;
                time_left     <= GAME_TIME;
                prescaler     <= '0;
            end else if (!game_enable && (state != IDLE)) begin
                // The game was left. The counters stay as they are for the game-over screen.
                state         <= IDLE;
                game_finished <= 1'b0;
            end else begin
                // The round timer runs only while a duck is being spawned or is in flight.
                if ((state == RESPAWN) || (state == ARMED)) begin
                    if (tick) begin
                        prescaler <= '0;
                        if (time_left != 8'd0) begin
                            time_left <= time_left - 8'd1;
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end

                case (state)
                    IDLE: begin
                        // Wait here for the next game start.
                    end

                    RESPAWN: begin
                        ammo <= AMMO_INIT;
                        if (timeout) begin
                            state         <= FINISHED;
                            game_finished <= 1'b1;
                        end else begin
                            state <= ARMED;
                        end
                    end

                    ARMED: begin
                        // When a hit and an escape arrive together, the hit wins.
                        if (duck_hit && (score != 8'hFF)) begin
                            score <= score + 8'd1;
                        end
                        if (resolve && (ducks_left != 8'd0)) begin
                            ducks_left <= ducks_left - 8'd1;
                        end
                        if (!resolve && shot && (ammo != 4'd0)) begin
                            ammo <= ammo - 4'd1;
                        end

                        // A time-out ends the round, even when a duck was resolved in the same cycle.
                        if (timeout || (resolve && last_duck)) begin
                            state         <= FINISHED;
                            game_finished <= 1'b1;
                        end else if (resolve) begin
                            state        <= RESPAWN;
                            duck_respawn <= 1'b1;
                            ammo         <= AMMO_INIT;
                        end
                    end

                    FINISHED: begin
                        // All counters are frozen until a restart or until the game is left.
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl. The timer is shrunk to 4 clocks per second,
// with 3 seconds per round, 2 ducks per game and 3 shots per duck.
module tb_game_round_ctrl;

    logic       clk;
    logic       rst;
    logic       game_enable;
    logic       game_enable_posedge;
    logic       left_mouse;
    logic       duck_hit;
    logic       duck_escaped;
    logic       game_finished;
    logic       duck_respawn;
    logic [7:0] score;
    logic [7:0] ducks_left;
    logic [3:0] ammo;
    logic [7:0] time_left;

    typedef struct packed {
        logic        ge;
        logic        gep;
        logic        lm;
        logic        hit;
        logic        esc;
        logic [29:0] expected;
    } vec_t;

    vec_t        vecs[$];
    logic [29:0] expq[$];
    int          checks;
    int          failures;

    game_round_ctrl #(
        .CLK_FREQ_HZ   (4),
        .GAME_TIME_S   (3),
        .DUCKS_PER_GAME(2),
        .AMMO_PER_DUCK (3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .game_enable        (game_enable),
        .game_enable_posedge(game_enable_posedge),
        .left_mouse         (left_mouse),
        .duck_hit           (duck_hit),
        .duck_escaped       (duck_escaped),
        .game_finished      (game_finished),
        .duck_respawn       (duck_respawn),
        .score              (score),
        .ducks_left         (ducks_left),
        .ammo               (ammo),
        .time_left          (time_left)
    );

    // Free-running clock with a 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stop a runaway simulation.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required end before 100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [29:0] pack_out(input logic gf, input logic dr, input int s,
                                             input int d, input int a, input int t);
        return {gf, dr, 8'(s), 8'(d), 4'(a), 8'(t)};
    endfunction

    function automatic vec_t mk(input logic ge, input logic gep, input logic lm, input logic hit,
                                input logic esc, input logic gf, input logic dr, input int s,
                                input int d, input int a, input int t);
        vec_t v;
        v.ge       = ge;
        v.gep      = gep;
        v.lm       = lm;
        v.hit      = hit;
        v.esc      = esc;
        v.expected = pack_out(gf, dr, s, d, a, t);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        game_enable         = v.ge;
        game_enable_posedge = v.gep;
        left_mouse          = v.lm;
        duck_hit            = v.hit;
        duck_escaped        = v.esc;
        expq.push_back(v.expected);
    endtask

    task automatic checkOutput(input string name);
        logic [29:0] act;
        logic [29:0] exp_v;
        act = {game_finished, duck_respawn, score, ducks_left, ammo, time_left};
        checks++;
        if (expq.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s: no expected value queued for the observed output %h", name, act);
        end else begin
            exp_v = expq.pop_front();
            if (act !== exp_v) begin
                failures++;
                $display("[TB] FAIL %s: got gf=%0d dr=%0d score=%0d ducks=%0d ammo=%0d time=%0d, expected gf=%0d dr=%0d score=%0d ducks=%0d ammo=%0d time=%0d",
                         name, act[29], act[28], act[27:20], act[19:12], act[11:8], act[7:0],
                         exp_v[29], exp_v[28], exp_v[27:20], exp_v[19:12], exp_v[11:8], exp_v[7:0]);
            end
        end
    endtask

    task automatic runVector(input vec_t v, input string name);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    initial begin
        checks              = 0;
        failures            = 0;
        rst                 = 1'b0;
        game_enable         = 1'b0;
        game_enable_posedge = 1'b0;
        left_mouse          = 1'b0;
        duck_hit            = 1'b0;
        duck_escaped        = 1'b0;

        // Vector table. Fields: ge gep lm hit esc | gf dr score ducks ammo time.
        vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,0));
        // Game A: two shots, a hit, then the second duck is hit and the game ends.
        vecs.push_back(mk(1,1,0,0,0, 0,1,0,2,3,3));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,2,3,3));
        vecs.push_back(mk(1,0,1,0,0, 0,0,0,2,2,3));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,2,2,3));
        vecs.push_back(mk(1,0,1,0,0, 0,0,0,2,1,2));
        vecs.push_back(mk(1,0,0,1,0, 0,1,1,1,3,2));
        vecs.push_back(mk(1,0,0,0,0, 0,0,1,1,3,2));
        vecs.push_back(mk(1,0,0,1,0, 1,0,2,0,3,2));
        vecs.push_back(mk(1,0,0,1,0, 1,0,2,0,3,2));
        vecs.push_back(mk(1,0,1,0,1, 1,0,2,0,3,2));
        vecs.push_back(mk(0,0,0,0,0, 0,0,2,0,3,2));
        vecs.push_back(mk(0,0,0,1,0, 0,0,2,0,3,2));
        // Game B: four shots and an escape, then a hit and an escape in the same cycle.
        vecs.push_back(mk(1,1,0,0,0, 0,1,0,2,3,3));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,2,3,3));
        vecs.push_back(mk(1,0,1,0,0, 0,0,0,2,2,3));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,2,2,3));
        vecs.push_back(mk(1,0,1,0,0, 0,0,0,2,1,2));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,2,1,2));
        vecs.push_back(mk(1,0,1,0,0, 0,0,0,2,0,2));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,2,0,2));
        vecs.push_back(mk(1,0,1,0,0, 0,0,0,2,0,1));
        vecs.push_back(mk(1,0,0,0,1, 0,1,0,1,3,1));
        vecs.push_back(mk(1,0,0,0,0, 0,0,0,1,3,1));
        vecs.push_back(mk(1,0,0,1,1, 1,0,1,0,3,1));
        // Game C: restart from FINISHED, let the timer run out, with a hit on the time-out cycle.
        vecs.push_back(mk(1,1,0,0,0, 0,1,0,2,3,3));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0,0, 0,0,0,2,3,3));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0,0, 0,0,0,2,3,2));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0,0, 0,0,0,2,3,1));
        vecs.push_back(mk(1,0,0,1,0, 1,0,1,1,3,0));
        vecs.push_back(mk(1,0,0,0,0, 1,0,1,1,3,0));

        // Asynchronous reset with no clock edge involved.
        #2;
        rst = 1'b1;
        #1;
        expq.push_back(pack_out(0, 0, 0, 0, 0, 0));
        checkOutput("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            runVector(vecs[i], $sformatf("vec[%0d]", i));
        end

        // Reset in the middle of ARMED, then release it with game_enable still high.
        runVector(mk(1,1,0,0,0, 0,1,0,2,3,3), "rst_seq_start");
        runVector(mk(1,0,0,0,0, 0,0,0,2,3,3), "rst_seq_armed");
        runVector(mk(1,0,1,0,0, 0,0,0,2,2,3), "rst_seq_shot");
        @(negedge clk);
        rst = 1'b1;
        #1;
        expq.push_back(pack_out(0, 0, 0, 0, 0, 0));
        checkOutput("rst_async_armed");
        @(negedge clk);
        rst = 1'b0;
        runVector(mk(1,0,0,0,0, 0,0,0,0,0,0), "rst_stay_idle_0");
        runVector(mk(1,0,0,1,0, 0,0,0,0,0,0), "rst_stay_idle_1");
        runVector(mk(1,1,0,0,0, 0,1,0,2,3,3), "rst_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 65_000_000, clk cycles per game-timer second.
REQ-002 Parameter GAME_TIME_S, default 60, round duration in seconds (1..255).
REQ-003 Parameter DUCKS_PER_GAME, default 10, ducks per game (1..255).
REQ-004 Parameter AMMO_PER_DUCK, default 3, shots per duck (1..15).
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 game_enable  input  1  level, high while the game-control FSM is in its running state.
REQ-008 game_enable_posedge  input  1  one-cycle pulse at game start.
REQ-009 left_mouse  input  1  mouse button level, already synchronous to clk.
REQ-010 duck_hit  input  1  one-cycle pulse, active duck was shot.
REQ-011 duck_escaped  input  1  one-cycle pulse, active duck left the screen.
REQ-012 game_finished  output  1  level, round over; consumed by the game-control FSM.
REQ-013 duck_respawn  output  1  one-cycle pulse, spawn the next duck.
REQ-014 score  output  8  ducks hit this game.
REQ-015 ducks_left  output  8  ducks not yet resolved.
REQ-016 ammo  output  4  shots remaining for the active duck.
REQ-017 time_left  output  8  seconds remaining.

Function
REQ-018 States: IDLE, RESPAWN, ARMED, FINISHED; all outputs registered.
REQ-019 Any state, game_enable_posedge: score<=0, ducks_left<=DUCKS_PER_GAME, ammo<=AMMO_PER_DUCK, time_left<=GAME_TIME_S, prescaler<=0, next state RESPAWN.
REQ-020 Any state other than IDLE, game_enable low and no game_enable_posedge: next state IDLE; score, ducks_left and time_left hold their values for the game-over screen.
REQ-021 RESPAWN: duck_respawn=1 for exactly one cycle; ammo<=AMMO_PER_DUCK; next state ARMED.
REQ-022 Shot: left_mouse rising edge (1 now, 0 the previous cycle) in ARMED with ammo>0 decrements ammo by 1; shots at ammo=0 are ignored.
REQ-023 ARMED with duck_hit: score+1, saturating at 255; ducks_left-1; next state RESPAWN, or FINISHED if ducks_left was 1.
REQ-024 ARMED with duck_escaped and no duck_hit: ducks_left-1, score unchanged; same next-state rule as REQ-023.
REQ-025 duck_hit and duck_escaped in the same cycle: treated as a hit only.
REQ-026 duck_hit and duck_escaped outside ARMED: ignored.
REQ-027 Timer: prescaler counts 0..CLK_FREQ_HZ-1 in RESPAWN and ARMED; on wrap, time_left-1.
REQ-028 time_left reaching 0: next state FINISHED, overriding any pending hit/escape transition; the hit/escape counter update in that same cycle still applies.
REQ-029 FINISHED: game_finished=1, all counters frozen; left only via REQ-019 or REQ-020.
REQ-030 game_finished is 0 in every other state; latency is 1 cycle from the terminating event to game_finished=1.
REQ-031 ducks_left, ammo and time_left never underflow below 0.

Reset
REQ-032 On rst: state IDLE; game_finished=0, duck_respawn=0, score=0, ducks_left=0, ammo=0, time_left=0; prescaler and the left_mouse history register cleared.
REQ-033 rst deasserted mid-game: the block stays in IDLE until the next game_enable_posedge.

Verification
(Bench parameters: CLK_FREQ_HZ=4, GAME_TIME_S=3, DUCKS_PER_GAME=2, AMMO_PER_DUCK=3.)
REQ-034 game_enable_posedge with game_enable held high -> duck_respawn pulses 1 cycle later, ammo=3, ducks_left=2, time_left=3.
REQ-035 Two left_mouse clicks, then duck_hit -> ammo 3,2,1; score=1, ducks_left=1, second duck_respawn pulse, ammo=3.
REQ-036 Four clicks, then duck_escaped -> ammo stays at 0 after the third click; ducks_left=1, score=0.
REQ-037 Second duck hit -> score=2, ducks_left=0, game_finished=1 next cycle, no further duck_respawn.
REQ-038 No hits for 12 cycles in ARMED -> time_left 3,2,1,0 every 4 cycles, game_finished=1; a duck_hit arriving in the same cycle as time-out still gives score+1.
REQ-039 rst asserted in ARMED -> all outputs read 0 immediately, without waiting for a clock edge; game_enable low in FINISHED -> game_finished=0, score held.
